// File: rtl/ps2_kbd_tx_if.sv
// Request handshake between a scan-code source and the PS/2 keyboard transmitter.
interface ps2_kbd_tx_if;
   logic [7:0] key_i;
   logic       key_break_i;
   logic       key_valid_i;
   logic       key_ready_o;

   modport master (
      output key_i,
      output key_break_i,
      output key_valid_i,
      input  key_ready_o
   );

   modport slave (
      input  key_i,
      input  key_break_i,
      input  key_valid_i,
      output key_ready_o
   );
endinterface

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: sends a make code, or F0 followed by the key for a break,
// as 11-bit odd-parity frames; host inhibit aborts and later retransmits the current byte.
module ps2_kbd_tx #(
   parameter int unsigned CLK_HALF = 16,
   parameter int unsigned GAP_CYC  = 32
) (
   input  logic         clk_i,
   input  logic         rst_n,
   ps2_kbd_tx_if.slave  kbd,
   input  logic         ps2_inhibit_i,
   output logic         ps2_clk_o,
   output logic         ps2_data_o,
   output logic         busy_o,
   output logic         abort_o
);

   localparam int unsigned HW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
   localparam int unsigned GW = $clog2(GAP_CYC + 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_HALF - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
   localparam logic [3:0]    STOP_BIT  = 4'd10;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP,
      WAIT_INH
   } state_t;

   state_t        state_q, state_d;
   logic [HW-1:0] half_q, half_d;
   logic          phase_q, phase_d;
   logic [3:0]    bit_q, bit_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    byte_q, byte_d;
   logic [7:0]    key_q, key_d;
   logic          pend_q, pend_d;
   logic          abort_q, abort_d;

   logic          accept;
   logic          frame_bit;
   logic [2:0]    data_idx;

   assign accept   = (state_q == IDLE) && kbd.key_valid_i && !ps2_inhibit_i;
   assign data_idx = 3'(bit_q - 4'd1);

   // Slot 0 is the start bit, 1..8 data LSB first, 9 odd parity, 10 stop.
   always_comb begin
      frame_bit = 1'b1;
      if (bit_q == 4'd0) begin
         frame_bit = 1'b0;
      end else if (bit_q <= 4'd8) begin
         frame_bit = byte_q[data_idx];
      end else if (bit_q == 4'd9) begin
         frame_bit = ~^byte_q;
      end
   end

   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      byte_d  = byte_q;
      key_d   = key_q;
      pend_d  = pend_q;
      abort_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               key_d   = kbd.key_i;
               pend_d  = kbd.key_break_i;
               byte_d  = kbd.key_break_i ? 8'hF0 : kbd.key_i;
               state_d = SHIFT;
               half_d  = '0;
               phase_d = 1'b0;
               bit_d   = '0;
            end
         end

         SHIFT: begin
            if (ps2_inhibit_i && (bit_q != STOP_BIT)) begin
               state_d = WAIT_INH;
               abort_d = 1'b1;
               gap_d   = '0;
               half_d  = '0;
               phase_d = 1'b0;
               bit_d   = '0;
            end else if (half_q == HALF_LAST) begin
               half_d = '0;
               if (phase_q) begin
                  phase_d = 1'b0;
                  if (bit_q == STOP_BIT) begin
                     state_d = GAP;
                     gap_d   = '0;
                     bit_d   = '0;
                  end else begin
                     bit_d = bit_q + 4'd1;
                  end
               end else begin
                  phase_d = 1'b1;
               end
            end else begin
               half_d = half_q + HW'(1);
            end
         end

         GAP: begin
            if (ps2_inhibit_i) begin
               gap_d = '0;
            end else if (gap_q == GAP_LAST) begin
               gap_d = '0;
               if (pend_q) begin
                  byte_d  = key_q;
                  pend_d  = 1'b0;
                  state_d = SHIFT;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end

         WAIT_INH: begin
            // byte_q and pend_q are untouched, so a completed F0 is not repeated
            if (ps2_inhibit_i) begin
               gap_d = '0;
            end else if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = SHIFT;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         half_q  <= '0;
         phase_q <= 1'b0;
         bit_q   <= '0;
         gap_q   <= '0;
         byte_q  <= '0;
         key_q   <= '0;
         pend_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         byte_q  <= byte_d;
         key_q   <= key_d;
         pend_q  <= pend_d;
         abort_q <= abort_d;
      end
   end

   assign ps2_clk_o       = (state_q == SHIFT) ? ~phase_q : 1'b1;
   assign ps2_data_o      = (state_q == SHIFT) ? frame_bit : 1'b1;
   assign busy_o          = (state_q != IDLE);
   assign kbd.key_ready_o = (state_q == IDLE);
   assign abort_o         = abort_q;

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface -- parameters
REQ-001 SHALL provide CLK_HALF, default 16, PS/2 clock half-period in clk_i cycles (minimum 2).
REQ-002 SHALL provide GAP_CYC, default 32, number of idle clk_i cycles required between consecutive frames (minimum 1).

Interface -- ports
REQ-003 SHALL provide clk_i, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL provide rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide key_i, input, 8, scan code to emit.
REQ-006 SHALL provide key_break_i, input, 1, where 1 means send a break sequence (F0 followed by key_i) and 0 means send a make code (key_i only).
REQ-007 SHALL provide key_valid_i, input, 1, request strobe.
REQ-008 SHALL provide key_ready_o, output, 1, high when a request can be accepted.
REQ-009 SHALL provide ps2_inhibit_i, input, 1, host inhibit (host holding the PS/2 clock line low), already synchronised.
REQ-010 SHALL provide ps2_clk_o, output, 1, device-driven PS/2 clock.
REQ-011 SHALL provide ps2_data_o, output, 1, device-driven PS/2 data.
REQ-012 SHALL provide busy_o, output, 1, high whenever the state is not IDLE.
REQ-013 SHALL provide abort_o, output, 1, a one-cycle pulse on each inhibit-caused frame abort.

Function
REQ-014 SHALL implement the states IDLE, SHIFT, GAP and WAIT_INH.
REQ-015 SHALL accept a request on a clock edge where key_valid_i, key_ready_o and ~ps2_inhibit_i are all high; key_ready_o SHALL be 1 only in IDLE.
REQ-016 On accept, SHALL latch key_i and key_break_i; the first byte sent SHALL be 8'hF0 if break, otherwise key_i.
REQ-017 SHALL ignore key_valid_i while busy_o is high, with no queueing and no effect on the frame in progress.
REQ-018 Each frame SHALL consist of 11 bits: start 0, data[0..7] LSB first, odd parity (~^data), stop 1.
REQ-019 Each bit slot SHALL last 2*CLK_HALF cycles: ps2_data_o updates at the slot start, ps2_clk_o is high for the first CLK_HALF cycles and low for the last CLK_HALF cycles.
REQ-020 The first frame SHALL begin in the cycle after accept (1-cycle latency): ps2_data_o=0 and ps2_clk_o=1 at that edge.
REQ-021 After the stop slot, SHALL enter GAP with ps2_clk_o=1, ps2_data_o=1 for GAP_CYC cycles; it SHALL then send the second byte (key_i) if a break is pending, otherwise go to IDLE.
REQ-022 Total time from accept to IDLE SHALL be 22*CLK_HALF+GAP_CYC cycles for a make, and 44*CLK_HALF+2*GAP_CYC cycles for a break.
REQ-023 If ps2_inhibit_i rises during SHIFT before the stop slot begins, SHALL abort the frame within 1 cycle, force ps2_clk_o=1 and ps2_data_o=1, pulse abort_o, and go to WAIT_INH.
REQ-024 If inhibit rises during the stop slot, SHALL complete the frame normally.
REQ-025 In WAIT_INH, once inhibit is low, SHALL wait GAP_CYC cycles and then retransmit the aborted byte from its start bit; a break in progress SHALL resume at the aborted byte (F0 is not resent if it already completed).
REQ-026 Inhibit during GAP SHALL extend the gap; the GAP_CYC count SHALL restart after inhibit falls.
REQ-027 The bit counter SHALL count 0..10, and the half-period counter SHALL count 0..CLK_HALF-1 and wrap.

Reset
REQ-028 On rst_n low (asynchronous, effective at any point including mid-frame), SHALL go to IDLE with ps2_clk_o=1, ps2_data_o=1, key_ready_o=1, busy_o=0, abort_o=0, all counters and latched data cleared, and no pending break.
REQ-029 After rst_n rises, the first accept SHALL be possible on the first clock edge.

Verification
REQ-030 Make 0x1C with CLK_HALF=4, GAP_CYC=8 -> data slots 0,0,0,1,1,1,0,0,0,parity 0,stop 1; idle after 96 cycles.
REQ-031 Break 0x1C -> frame F0 (data 0,0,0,0,1,1,1,1, parity 1), 8-cycle gap, frame 1C; busy_o high for 192 cycles.
REQ-032 key_valid_i pulsed with 0x55 during a 0x1C frame -> 0x1C is sent unchanged, 0x55 is never sent, key_ready_o stays low.
REQ-033 Inhibit asserted in bit slot 5 of the key byte of a break -> abort_o pulses, lines go high, and after release plus gap only 0x1C is resent (no F0).
REQ-034 rst_n low in slot 3 -> ps2_clk_o=1 and ps2_data_o=1 immediately; a new make 0x29 after release is sent cleanly.
REQ-035 Sample ps2_data_o on every ps2_clk_o falling edge against a reference deserialiser across 256 random make/break codes -> zero mismatches and parity always odd.
